// File: rtl/rv32i_types.sv
// Shared types for the writeback / common-data-bus path.
//   fu_result_t : one completed result as produced by a functional unit and
//                 broadcast on a CDB lane (ROB tag, physical/arch dest, value,
//                 retirement-trace payload).
//   fu_id_e     : identity of each FU result port, also its port index.
package rv32i_types;

   localparam int ROB_ID_W = 5;
   localparam int PREG_W   = 6;
   localparam int AREG_W   = 5;

   // Retirement trace payload carried alongside each result.
   typedef struct packed {
      logic        valid;
      logic [15:0] order;
      logic [31:0] pc;
   } rvfi_t;

   typedef struct packed {
      logic [ROB_ID_W-1:0] rob_id;
      logic [PREG_W-1:0]   pd;
      logic [AREG_W-1:0]   rd;
      logic [31:0]         value;
      rvfi_t               rvfi;
   } fu_result_t;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_MUL = 2'd1,
      FU_DIV = 2'd2,
      FU_LSU = 2'd3
   } fu_id_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB arbiter.
//   fu_valid/fu_ready/fu_result : per-FU result handshake (FU -> arbiter)
//   cdb_valid/cdb_out           : registered broadcast lanes (arbiter -> ROB/RS/PRF)
//   fu_occupancy                : per-port FIFO fill level for perf counters
//   rr_ptr                      : round-robin start index, exposed for observation
// Handshake: a result on port i transfers at a rising edge where fu_valid[i]
// and fu_ready[i] are both high. fu_ready never depends on fu_valid in the same
// cycle; an FU may hold or withdraw fu_valid freely while fu_ready is low.
interface cdb_arbiter_if #(
   parameter int SS         = 2,
   parameter int N_FU       = 4,
   parameter int FIFO_DEPTH = 4
);
   import rv32i_types::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(N_FU);

   logic       [N_FU-1:0]         fu_valid;
   logic       [N_FU-1:0]         fu_ready;
   fu_result_t [N_FU-1:0]         fu_result;
   logic       [SS-1:0]           cdb_valid;
   fu_result_t [SS-1:0]           cdb_out;
   logic       [N_FU-1:0][CW-1:0] fu_occupancy;
   logic       [IW-1:0]           rr_ptr;

   // FU side
   modport master (
      output fu_valid, fu_result,
      input  fu_ready, cdb_valid, cdb_out, fu_occupancy, rr_ptr
   );

   // Arbiter side
   modport slave (
      input  fu_valid, fu_result,
      output fu_ready, cdb_valid, cdb_out, fu_occupancy, rr_ptr
   );

endinterface

// File: rtl/cdb_port_fifo.sv
// Small per-port result FIFO.
//   clk, rst  : clock, asynchronous active-low reset
//   push_i    : write din_i (ignored when full or flushing)
//   pop_i     : drop the head (ignored when empty or flushing)
//   flush_i   : empty the FIFO; wins over push and pop in the same cycle
//   din_i     : entry to write
//   head_o    : oldest entry; meaningless while count_o == 0
//   count_o   : number of valid entries
// Storage is not reset; only pointers and count are.
module cdb_port_fifo
   import rv32i_types::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fu_result_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  T                           din_i,
   output T                           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   T              mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i  && !flush_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are exactly log2(DEPTH) wide, so +1 wraps on its own.
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback-stage CDB arbiter. Buffers completed results from N_FU ports in
// per-port FIFOs and broadcasts up to SS of them per cycle on registered lanes.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   flush : mispredict flush, drops everything buffered and in flight
//   bus   : FU handshakes, CDB lanes, occupancy and rr_ptr (cdb_arbiter_if.slave)
// Ports are served round-robin starting at rr_ptr; after any grant rr_ptr
// moves one past the last granted port, so no non-empty port is skipped for
// more than ceil(N_FU/SS) grant cycles.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int SS         = 2,
   parameter int N_FU       = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(N_FU);
   localparam int LW = (SS > 1) ? $clog2(SS) : 1;

   logic       [N_FU-1:0][CW-1:0] count;
   fu_result_t [N_FU-1:0]         head;
   logic       [N_FU-1:0]         ready;
   logic       [N_FU-1:0]         push;
   logic       [N_FU-1:0]         grant;

   logic       [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic       [SS-1:0]           cdb_valid_q, cdb_valid_d;
   fu_result_t [SS-1:0]           cdb_out_q, cdb_out_d;

   // Ready looks only at the registered count: a full FIFO that is popped
   // this cycle still refuses the push.
   always_comb begin
      for (int i = 0; i < N_FU; i++) begin
         ready[i] = !flush && (count[i] < CW'(FIFO_DEPTH));
      end
   end

   assign push = bus.fu_valid & ready;

   for (genvar g = 0; g < N_FU; g++) begin : g_port
      cdb_port_fifo #(
         .DEPTH (FIFO_DEPTH),
         .T     (fu_result_t)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[g]),
         .pop_i   (grant[g]),
         .flush_i (flush),
         .din_i   (bus.fu_result[g]),
         .head_o  (head[g]),
         .count_o (count[g])
      );
   end

   // Scan ports from rr_ptr; each non-empty port takes the next free lane.
   always_comb begin
      int            idx_i;
      int            lanes;
      int            last;
      logic [IW-1:0] idx_v;
      logic [LW-1:0] lane_v;
      grant       = '0;
      cdb_valid_d = '0;
      cdb_out_d   = cdb_out_q;
      rr_ptr_d    = rr_ptr_q;
      idx_i       = 0;
      lanes       = 0;
      last        = 0;
      idx_v       = '0;
      lane_v      = '0;
      for (int k = 0; k < N_FU; k++) begin
         idx_i = int'(rr_ptr_q) + k;
         if (idx_i >= N_FU) idx_i = idx_i - N_FU;
         idx_v  = IW'(idx_i);
         lane_v = LW'(lanes);
         if ((count[idx_v] != '0) && (lanes < SS)) begin
            grant[idx_v]        = 1'b1;
            cdb_valid_d[lane_v] = 1'b1;
            cdb_out_d[lane_v]   = head[idx_v];
            lanes               = lanes + 1;
            last                = idx_i;
         end
      end
      if (lanes != 0) begin
         rr_ptr_d = (last == N_FU - 1) ? '0 : IW'(last + 1);
      end
   end

   // Flush cancels this cycle's grants: the FIFOs ignore the pops, so the
   // lanes and rr_ptr must not advance either. Idle lanes keep their payload.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_out_q   <= '0;
      end else if (flush) begin
         cdb_valid_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_out_q   <= cdb_out_d;
      end
   end

   assign bus.fu_ready     = ready;
   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_out      = cdb_out_q;
   assign bus.fu_occupancy = count;
   assign bus.rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by a long
// randomized run, all checked against a queue-based reference model.
module tb_cdb_arbiter;
   import rv32i_types::*;

   localparam int SS   = 2;
   localparam int N_FU = 4;
   localparam int FD   = 4;
   localparam int RW   = $bits(fu_result_t);

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;

   cdb_arbiter_if #(.SS(SS), .N_FU(N_FU), .FIFO_DEPTH(FD)) dif ();

   cdb_arbiter #(.SS(SS), .N_FU(N_FU), .FIFO_DEPTH(FD)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (dif)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   int                    n_cmp = 0;
   int                    n_err = 0;
   logic [RW-1:0]         exp_q [N_FU][$];
   int                    rr_m = 0;
   int                    wait_m [N_FU];
   int                    max_wait = 0;
   int                    n_acc = 0;
   int                    n_bc = 0;
   int                    n_drop = 0;
   int                    seq = 0;
   logic [N_FU-1:0]       acc_v;
   logic [N_FU-1:0]       pend = '0;
   fu_result_t [N_FU-1:0] drv_r;

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic fu_result_t mk_res(input int port);
      fu_result_t r;
      r            = '0;
      r.rob_id     = ROB_ID_W'($urandom);
      r.pd         = PREG_W'($urandom);
      r.rd         = AREG_W'($urandom);
      r.value      = {8'(port), 24'(seq)};
      r.rvfi.valid = 1'b1;
      r.rvfi.order = 16'(seq);
      r.rvfi.pc    = $urandom;
      seq++;
      return r;
   endfunction

   function automatic bit model_empty();
      for (int i = 0; i < N_FU; i++) if (exp_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock cycle: present inputs, predict from the model, compare after the edge.
   task automatic step(input logic [N_FU-1:0] v, input logic fl);
      logic [N_FU-1:0]  rdy_m;
      logic [N_FU-1:0]  pop_m;
      logic [SS-1:0]    cv_m;
      fu_result_t [SS-1:0] co_m;
      int lanes;
      int last;
      int idx;
      @(negedge clk);
      dif.fu_valid  = v;
      dif.fu_result = drv_r;
      flush         = fl;
      #1;
      for (int i = 0; i < N_FU; i++) rdy_m[i] = !fl && (exp_q[i].size() < FD);
      check("fu_ready", 160'(dif.fu_ready), 160'(rdy_m));
      cv_m  = '0;
      co_m  = '0;
      pop_m = '0;
      lanes = 0;
      last  = 0;
      if (!fl) begin
         for (int k = 0; k < N_FU; k++) begin
            idx = (rr_m + k) % N_FU;
            if (exp_q[idx].size() > 0 && lanes < SS) begin
               co_m[lanes] = exp_q[idx][0];
               cv_m[lanes] = 1'b1;
               pop_m[idx]  = 1'b1;
               lanes++;
               last = idx;
            end
         end
      end
      acc_v = v & rdy_m;
      if (lanes > 0) begin
         for (int i = 0; i < N_FU; i++) begin
            if (pop_m[i]) wait_m[i] = 0;
            else if (exp_q[i].size() > 0) begin
               wait_m[i]++;
               if (wait_m[i] > max_wait) max_wait = wait_m[i];
            end
         end
         rr_m = (last + 1) % N_FU;
      end
      if (fl) begin
         for (int i = 0; i < N_FU; i++) begin
            n_drop += exp_q[i].size();
            exp_q[i].delete();
            wait_m[i] = 0;
         end
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (pop_m[i]) void'(exp_q[i].pop_front());
            if (acc_v[i]) begin
               exp_q[i].push_back(drv_r[i]);
               n_acc++;
            end
         end
      end
      n_bc += lanes;
      @(posedge clk);
      #1;
      check("cdb_valid", 160'(dif.cdb_valid), 160'(cv_m));
      for (int j = 0; j < SS; j++) begin
         if (cv_m[j]) check("cdb_out", 160'(dif.cdb_out[j]), 160'(co_m[j]));
      end
      for (int i = 0; i < N_FU; i++) begin
         check("occupancy", 160'(dif.fu_occupancy[i]), 160'(exp_q[i].size()));
      end
      check("rr_ptr", 160'(dif.rr_ptr), 160'(rr_m));
   endtask

   // FU behaviour: a result stays presented until accepted; a flush kills it.
   task automatic drive(input logic [N_FU-1:0] want, input logic fl);
      for (int i = 0; i < N_FU; i++) begin
         if (!pend[i] && want[i]) begin
            drv_r[i] = mk_res(i);
            pend[i]  = 1'b1;
         end
      end
      step(pend, fl);
      pend = pend & ~acc_v;
      if (fl) pend = '0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((!model_empty() || pend != '0) && budget < 64) begin
         drive('0, 1'b0);
         budget++;
      end
      check("drain_done", 160'(model_empty()), 160'(1));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_FU; i++) begin
         exp_q[i].delete();
         wait_m[i] = 0;
      end
      rr_m = 0;
      pend = '0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cnt1;
      int budget;
      for (int i = 0; i < N_FU; i++) begin
         wait_m[i] = 0;
         drv_r[i]  = mk_res(i);
      end
      // Reset held with every FU presenting a result.
      dif.fu_valid  = 4'b1111;
      dif.fu_result = drv_r;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cdb_valid", 160'(dif.cdb_valid), 160'(0));
      for (int i = 0; i < N_FU; i++) check("reset_occupancy", 160'(dif.fu_occupancy[i]), 160'(0));
      check("reset_rr_ptr", 160'(dif.rr_ptr), 160'(0));
      dif.fu_valid = '0;
      rst = 1'b1;
      #1;
      check("reset_fu_ready", 160'(dif.fu_ready), 160'(4'b1111));

      // Single push on port 2: broadcast two edges later on lane 0.
      drv_r[2]       = mk_res(2);
      drv_r[2].value = 32'hDEAD_BEEF;
      pend[2]        = 1'b1;
      step(pend, 1'b0);
      pend = pend & ~acc_v;
      check("single_not_early", 160'(dif.cdb_valid), 160'(0));
      drive('0, 1'b0);
      check("single_valid", 160'(dif.cdb_valid), 160'(2'b01));
      check("single_value", 160'(dif.cdb_out[0].value), 160'(32'hDEAD_BEEF));
      check("single_rr", 160'(dif.rr_ptr), 160'(3));

      // Bring rr_ptr to 0 through port 3, then all four ports at once.
      drive(4'b1000, 1'b0);
      drive('0, 1'b0);
      check("rr_wrap", 160'(dif.rr_ptr), 160'(0));
      drive(4'b1111, 1'b0);
      drive('0, 1'b0);
      check("rr_first_valid", 160'(dif.cdb_valid), 160'(2'b11));
      check("rr_first_l0", 160'(dif.cdb_out[0].value[31:24]), 160'(0));
      check("rr_first_l1", 160'(dif.cdb_out[1].value[31:24]), 160'(1));
      drive('0, 1'b0);
      check("rr_second_l0", 160'(dif.cdb_out[0].value[31:24]), 160'(2));
      check("rr_second_l1", 160'(dif.cdb_out[1].value[31:24]), 160'(3));
      check("rr_after", 160'(dif.rr_ptr), 160'(0));

      // Backpressure: port 1 sends five results against three saturated ports.
      cnt1   = 0;
      budget = 0;
      while (cnt1 < 5 && budget < 80) begin
         drive((cnt1 < 5 && !pend[1]) ? 4'b1111 : 4'b1101, 1'b0);
         if (acc_v[1]) cnt1++;
         budget++;
      end
      check("backpressure_accepts", 160'(cnt1), 160'(5));
      drain();

      // Flush with buffered results and a concurrent push on port 1.
      repeat (3) drive(4'b1001, 1'b0);
      drive(4'b0010, 1'b1);
      flush = 1'b0;
      check("flush_cdb_valid", 160'(dif.cdb_valid), 160'(0));
      for (int i = 0; i < N_FU; i++) check("flush_occupancy", 160'(dif.fu_occupancy[i]), 160'(0));
      drive('0, 1'b0);
      check("flush_push_lost", 160'(dif.cdb_valid), 160'(0));

      // Asynchronous reset in the middle of traffic.
      repeat (2) drive(4'b1111, 1'b0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset_cdb_valid", 160'(dif.cdb_valid), 160'(0));
      for (int i = 0; i < N_FU; i++) check("midreset_occupancy", 160'(dif.fu_occupancy[i]), 160'(0));
      dif.fu_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      n_acc  = 0;
      n_bc   = 0;
      n_drop = 0;

      // Sustained random load with rare flushes.
      for (int c = 0; c < 10000; c++) begin
         drive(N_FU'($urandom), ($urandom_range(0, 499) == 0));
      end
      flush = 1'b0;
      drain();
      check("every_result_once", 160'(n_bc + n_drop), 160'(n_acc));
      check("no_starvation", 160'(max_wait <= 2), 160'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard stop in case anything above stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
